// File: rtl/multadd_arbiter.sv
// Arbitrates NUM_REQ requesters onto one pipelined multiply-add unit and returns tagged results.
// Define MULTADD_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module multadd_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int MUL_LAT = 4,
    parameter  int AW      = 16,
    parameter  int CW      = 4,
    parameter  int PW      = 48,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_a,
    input  logic [NUM_REQ*AW-1:0] req_b,
    input  logic [NUM_REQ*CW-1:0] req_c,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic                  mul_ce,
    output logic                  mul_sclr,
    output logic [AW-1:0]         mul_a,
    output logic [AW-1:0]         mul_b,
    output logic [CW-1:0]         mul_c,
    output logic                  mul_sub,
    input  logic [PW-1:0]         mul_p,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [PW-1:0]         rsp_p,
    output logic                  busy
);

    logic                          r_sclr;
    logic [MUL_LAT-1:0]            r_vld;
    logic [MUL_LAT-1:0][IDW-1:0]   r_id;

    logic                          w_stall;
    logic                          w_allow;
    logic                          w_found;
    logic                          w_issue;
    logic [IDW-1:0]                w_gid;

    assign rsp_valid = r_vld[MUL_LAT-1];
    assign rsp_id    = r_id[MUL_LAT-1];
    assign rsp_p     = mul_p;
    assign busy      = |r_vld;

    // A held response freezes the whole multadd pipeline, so results keep their slot.
    assign w_stall   = rsp_valid & ~rsp_ready;
    assign mul_ce    = ~w_stall;
    assign mul_sclr  = flush | r_sclr;
    assign w_allow   = ~w_stall & ~mul_sclr;
    assign w_issue   = w_allow & w_found;

    // Holds the multadd in clear for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclr <= 1'b1;
        end else begin
            r_sclr <= 1'b0;
        end
    end

`ifdef MULTADD_RR_EN
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gid   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NUM_REQ - 1);
        end else if (w_issue) begin
            r_ptr <= w_gid;
        end
    end
`else
    logic [IDW-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDW'(k);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gid   = w_cand;
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        mul_c     = '0;
        mul_sub   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_issue && (w_gid == IDW'(i))) begin
                req_ready[i] = 1'b1;
                mul_a        = req_a[i*AW +: AW];
                mul_b        = req_b[i*AW +: AW];
                mul_c        = req_c[i*CW +: CW];
                mul_sub      = req_sub[i];
            end
        end
    end

    // Tag pipe tracks the multadd stages one-for-one, advancing only with CE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_id  <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (mul_ce) begin
            r_vld[0] <= w_issue;
            r_id[0]  <= w_gid;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
        end
    end

endmodule

// File: tb/tb_multadd_arbiter.sv
// Self-checking bench for multadd_arbiter with a behavioural multadd and a response scoreboard.
module tb_multadd_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 4;
    localparam int AW      = 16;
    localparam int CW      = 4;
    localparam int PW      = 48;
    localparam int IDW     = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_a;
    logic [NUM_REQ*AW-1:0] req_b;
    logic [NUM_REQ*CW-1:0] req_c;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  mul_ce;
    logic                  mul_sclr;
    logic [AW-1:0]         mul_a;
    logic [AW-1:0]         mul_b;
    logic [CW-1:0]         mul_c;
    logic                  mul_sub;
    logic [PW-1:0]         mul_p;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [PW-1:0]         rsp_p;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = NUM_REQ - 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  p;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    multadd_arbiter #(
        .NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .AW(AW), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_sub(req_sub),
        .mul_ce(mul_ce), .mul_sclr(mul_sclr),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_sub(mul_sub),
        .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] calc(logic [AW-1:0] a, logic [AW-1:0] b,
                                           logic [CW-1:0] c, logic s);
        logic [PW-1:0] pr;
        pr = PW'(a) * PW'(b);
        return s ? (pr - PW'(c)) : (pr + PW'(c));
    endfunction

    // Behavioural multadd: MUL_LAT registered stages, CE-gated, synchronous clear.
    logic [PW-1:0] mp [MUL_LAT];
    assign mul_p = mp[MUL_LAT-1];
    always @(posedge clk) begin
        if (mul_sclr) begin
            for (int k = 0; k < MUL_LAT; k++) mp[k] <= '0;
        end else if (mul_ce) begin
            mp[0] <= calc(mul_a, mul_b, mul_c, mul_sub);
            for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
        end
    end

    // Scoreboard: pop on accepted response, then push on accepted request.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_stray: got id=%0d p=%0h, required no response", rsp_id, rsp_p);
                end else begin
                    mon_e = sb.pop_front();
                    if (rsp_id !== mon_e.id || rsp_p !== mon_e.p) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got id=%0d p=%0h, required id=%0d p=%0h",
                                 rsp_id, rsp_p, mon_e.id, mon_e.p);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i])
                    sb.push_back({IDW'(i), calc(req_a[i*AW +: AW], req_b[i*AW +: AW],
                                                req_c[i*CW +: CW], req_sub[i])});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [AW-1:0] b, logic [CW-1:0] c, logic s);
        req_a[i*AW +: AW] = a;
        req_b[i*AW +: AW] = b;
        req_c[i*CW +: CW] = c;
        req_sub[i]        = s;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_sub = '0;
        set_req(0, 16'd3, 16'd5, 4'd2, 1'b0);
        req_valid = 4'b0001;
        step(); step();
        mid();
        n_checks++;
        if (mul_sclr !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || mul_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_vals: got sclr=%b rsp_valid=%b busy=%b ready=%b ce=%b, required 1 0 0 0000 1",
                     mul_sclr, rsp_valid, busy, req_ready, mul_ce);
        end
        step();
        rst_n = 1'b1;
        exp_ptr = NUM_REQ - 1;
        mid();
        n_checks++;
        if (mul_sclr !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_sclr_pulse: got sclr=%b ready=%b, required 1 0000", mul_sclr, req_ready);
        end
    endtask

    task automatic test_basic();
        step();
        mid();
        n_checks++;
        if (mul_sclr !== 1'b0 || req_ready !== 4'b0001 || mul_a !== 16'd3 || mul_b !== 16'd5 ||
            mul_c !== 4'd2 || mul_sub !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_issue: got sclr=%b ready=%b a=%0d b=%0d c=%0d sub=%b, required 0 0001 3 5 2 0",
                     mul_sclr, req_ready, mul_a, mul_b, mul_c, mul_sub);
        end
        exp_ptr = 0;
        for (int k = 1; k <= MUL_LAT; k++) begin
            step();
            if (k == 1) req_valid = '0;
            mid();
            n_checks++;
            if (k < MUL_LAT) begin
                if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_inflight: cycle %0d got rsp_valid=%b busy=%b, required 0 1", k, rsp_valid, busy);
                end
            end else if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 48'd17 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_rsp: got valid=%b id=%0d p=%0d busy=%b, required 1 0 17 1",
                         rsp_valid, rsp_id, rsp_p, busy);
            end
        end
        step();
        mid();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_sub();
        step();
        set_req(2, 16'd3, 16'd5, 4'd2, 1'b1);
        req_valid = 4'b0100;
        mid();
        n_checks++;
        if (req_ready !== 4'b0100 || mul_sub !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_issue: got ready=%b sub=%b, required 0100 1", req_ready, mul_sub);
        end
        exp_ptr = 2;
        for (int k = 1; k <= MUL_LAT; k++) begin
            step();
            if (k == 1) req_valid = '0;
            mid();
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 48'd13) begin
            n_fail++;
            $display("FAIL sub_rsp: got valid=%b id=%0d p=%0d, required 1 2 13", rsp_valid, rsp_id, rsp_p);
        end
    endtask

    task automatic test_arbitration();
        int exp_g;
        bit ok;
        for (int c = 0; c < 12; c++) begin
            step();
            req_valid = '1;
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, AW'($urandom), AW'($urandom), CW'($urandom), 1'($urandom));
            mid();
`ifdef MULTADD_RR_EN
            exp_g = (exp_ptr + 1) % NUM_REQ;
`else
            exp_g = 0;
`endif
            exp_ptr = exp_g;
            n_checks++;
            if (req_ready !== NUM_REQ'(1 << exp_g)) begin
                n_fail++;
                $display("FAIL arb_grant: cycle %0d got ready=%b, required requester %0d", c, req_ready, exp_g);
            end
            if (c >= MUL_LAT) begin
                n_checks++;
                if (rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL arb_throughput: cycle %0d got rsp_valid=%b, required 1", c, rsp_valid);
                end
            end
        end
        step();
        req_valid = '0;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL arb_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0]  held_p;
        logic [IDW-1:0] held_id;
        bit ok;
        for (int c = 0; c < 8; c++) begin
            step();
            req_valid = 4'b0001;
            set_req(0, AW'(c + 1), 16'd7, CW'(c), 1'b0);
            mid();
            n_checks++;
            if (req_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL b2b_issue: cycle %0d got ready=%b, required 0001", c, req_ready);
            end
        end
        exp_ptr = 0;
        held_p = '0;
        held_id = '0;
        for (int s = 0; s < 3; s++) begin
            step();
            rsp_ready = 1'b0;
            mid();
            if (s == 0) begin
                held_p  = rsp_p;
                held_id = rsp_id;
            end
            n_checks++;
            if (mul_ce !== 1'b0 || req_ready !== 4'b0000 || rsp_valid !== 1'b1 ||
                rsp_p !== held_p || rsp_id !== held_id) begin
                n_fail++;
                $display("FAIL b2b_stall: cycle %0d got ce=%b ready=%b valid=%b p=%0h id=%0d, required 0 0000 1 %0h %0d",
                         s, mul_ce, req_ready, rsp_valid, rsp_p, rsp_id, held_p, held_id);
            end
        end
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        bit ok;
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = 4'b0010;
            set_req(1, AW'(100 + c), 16'd9, 4'd1, 1'b0);
            mid();
            n_checks++;
            if (req_ready !== 4'b0010) begin
                n_fail++;
                $display("FAIL flush_issue: cycle %0d got ready=%b, required 0010", c, req_ready);
            end
        end
        exp_ptr = 1;
        step();
        req_valid = 4'b0001;
        set_req(0, 16'd11, 16'd12, 4'd3, 1'b0);
        flush = 1'b1;
        mid();
        n_checks++;
        if (mul_sclr !== 1'b1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: got sclr=%b ready=%b busy=%b, required 1 0000 1", mul_sclr, req_ready, busy);
        end
        step();
        flush = 1'b0;
        sb.delete();
        mid();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001 || mul_sclr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got valid=%b busy=%b ready=%b sclr=%b, required 0 0 0001 0",
                     rsp_valid, busy, req_ready, mul_sclr);
        end
        exp_ptr = 0;
        step();
        req_valid = '0;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int c = 0; c < 2; c++) begin
            step();
            req_valid = 4'b0100;
            set_req(2, AW'(40 + c), 16'd2, 4'd5, 1'b1);
            mid();
            n_checks++;
            if (req_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL rstmid_issue: cycle %0d got ready=%b, required 0100", c, req_ready);
            end
        end
        step();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_sclr !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b valid=%b sclr=%b ready=%b, required 0 0 1 0000",
                     busy, rsp_valid, mul_sclr, req_ready);
        end
        sb.delete();
        exp_ptr = NUM_REQ - 1;
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            mid();
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stray: cycle %0d got valid=%b busy=%b, required 0 0", c, rsp_valid, busy);
            end
        end
        step();
        req_valid = '1;
        mid();
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_first_grant: got ready=%b, required 0001", req_ready);
        end
        step();
        req_valid = '0;
        drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
